control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 The block SHALL use one clock, `clock`; `clear` SHALL be the synchronous, active-high reset.
REQ-002 Ports SHALL be exactly these (name, direction, width, meaning):
- clock  in  1  system clock, rising edge.
- clear  in  1  synchronous active-high reset.
- IR  in  32  instruction register contents from datapath.
- PCout, IncPC, MARin, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, Yin, LOin, HIin  out  1 each  datapath strobes.
- alu_op  out  5  ALU operation select; 00000 = idle.
- Rin  out  16  one-hot general-register load enables.
- Rout  out  16  one-hot general-register bus-drive enables.
- Run  out  1  1 = executing, 0 = halted.
- step  out  4  current state code, for debug.
REQ-003 IR fields SHALL be: opcode = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15].

Function
REQ-004 The block SHALL be a Moore FSM; every output SHALL be decoded only from the state register and IR, and the datapath samples outputs on the next rising clock edge.
REQ-005 States (step code): T0=0, T1=1, T2=2, T3=3, T4=4, T5=5, T6=6, HALT=15; each non-HALT state SHALL last exactly one cycle.
REQ-006 Fetch SHALL be:
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin.
- T2: MDRout, IRin.
- Transition out of T2: to T3, except as REQ-011 and REQ-012 state.
REQ-007 Opcode table:
- add 00011, sub 00100, and 00101, or 00110.
- shr 00111, sra 01000, shl 01001, ror 01010, rol 01011.
- mul 01111, div 10000, neg 10001, not 10010.
- nop 11010, halt 11011.
- alu_op SHALL equal the opcode while the ALU-evaluate state is active.
REQ-008 Binary ALU ops (add through rol) SHALL run:
- T3: Rout[Rb], Yin.
- T4: Rout[Rc], alu_op, Zin.
- T5: Zlowout, Rin[Ra].
- Then T0. Total 6 cycles.
REQ-009 mul and div SHALL run:
- T3: Rout[Ra], Yin.
- T4: Rout[Rb], alu_op, Zin.
- T5: Zlowout, LOin.
- T6: Zhighout, HIin.
- Then T0. Total 7 cycles. Rin SHALL stay 0.
REQ-010 neg and not SHALL run:
- T3: Rout[Rb], alu_op, Zin.
- T4: Zlowout, Rin[Ra].
- Then T0. Total 5 cycles.
REQ-011 nop and every undefined opcode SHALL go from T2 to T0 with no execute-phase strobes.
REQ-012 halt SHALL go from T2 to HALT. In HALT, Run=0 and all strobes, alu_op, Rin and Rout are 0; HALT SHALL be left only by clear.
REQ-013 Rin and Rout SHALL each have at most one bit set, with bit n selecting Rn; Rin and Rout SHALL never be nonzero in the same cycle.
REQ-014 The state-dependent opcode SHALL be taken from IR sampled in T3 onward; IR changes during T0–T2 SHALL NOT affect the T2 transition other than through the IR value present in T2.
REQ-015 Strobes not listed for a state SHALL be 0; Read and MDRin SHALL never be asserted outside T1.

Reset
REQ-016 clear=1 at a rising edge SHALL force state T0 and Run=1 on the following cycle, from any state including HALT and mid-instruction.
REQ-017 While clear=1, all strobes, alu_op, Rin and Rout SHALL be 0.
REQ-018 The first cycle after clear deasserts SHALL be T0, with T0 strobes asserted.

Verification
REQ-019 "and R1,R2,R3": IR=0x28918000 after T2. Required:
- T3: Rout=0x0004, Yin.
- T4: Rout=0x0008, alu_op=00101, Zin.
- T5: Zlowout, Rin=0x0002.
- Then T0.
REQ-020 "mul R4,R5": IR=0x7A280000. Required:
- T3: Rout=0x0010, Yin.
- T4: Rout=0x0020, alu_op=01111, Zin.
- T5: Zlowout, LOin.
- T6: Zhighout, HIin.
- Then T0.
REQ-021 nop: IR=0xD0000000 gives T0→T1→T2→T0, 3 cycles, with no Rin, Rout or alu_op activity.
REQ-022 halt: IR=0xD8000000 gives HALT with step=15 and Run=0, and the unit stays in HALT for 20 further cycles; a 1-cycle clear then gives T0 with Run=1.
REQ-023 Mid-instruction reset: clear asserted in T4 of the "and" instruction gives T0 on the next cycle; Rin[1] SHALL never assert.
REQ-024 Fetch check: during every T0, PCout=MARin=IncPC=Zin=1; during every T1, Read=MDRin=PCin=Zlowout=1; during every T2, MDRout=IRin=1.

Source files
------------

// File: rtl/control_unit_if.sv
// Control-unit/datapath bus: instruction register in, datapath strobes and status out.
interface control_unit_if;
  logic [31:0] IR;
  logic        PCout;
  logic        IncPC;
  logic        MARin;
  logic        Zin;
  logic        Zlowout;
  logic        Zhighout;
  logic        PCin;
  logic        Read;
  logic        MDRin;
  logic        MDRout;
  logic        IRin;
  logic        Yin;
  logic        LOin;
  logic        HIin;
  logic [4:0]  alu_op;
  logic [15:0] Rin;
  logic [15:0] Rout;
  logic        Run;
  logic [3:0]  step;

  // Control unit side: reads IR, drives every strobe.
  modport master (
    input  IR,
    output PCout, IncPC, MARin, Zin, Zlowout, Zhighout, PCin, Read, MDRin,
           MDRout, IRin, Yin, LOin, HIin, alu_op, Rin, Rout, Run, step
  );

  // Datapath side: supplies IR, consumes the strobes.
  modport slave (
    output IR,
    input  PCout, IncPC, MARin, Zin, Zlowout, Zhighout, PCin, Read, MDRin,
           MDRout, IRin, Yin, LOin, HIin, alu_op, Rin, Rout, Run, step
  );
endinterface

// File: rtl/control_unit.sv
// Hardwired Moore control unit: fetch (T0-T2), per-class execute phases, sticky HALT.
module control_unit (
  input  logic              clock,
  input  logic              clear,
  control_unit_if.master    bus
);

  typedef enum logic [3:0] {
    T0   = 4'd0,
    T1   = 4'd1,
    T2   = 4'd2,
    T3   = 4'd3,
    T4   = 4'd4,
    T5   = 4'd5,
    T6   = 4'd6,
    HALT = 4'd15
  } state_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  state_t state;
  state_t next_state;

  logic [4:0] opcode;
  logic [3:0] ra;
  logic [3:0] rb;
  logic [3:0] rc;
  logic       is_binary;
  logic       is_muldiv;
  logic       is_unary;
  logic       is_halt;
  logic       is_exec;
  logic       unused_ir;

  assign opcode    = bus.IR[31:27];
  assign ra        = bus.IR[26:23];
  assign rb        = bus.IR[22:19];
  assign rc        = bus.IR[18:15];
  assign unused_ir = &{1'b0, bus.IR[14:0]};

  // Opcode classes; nop and undefined opcodes fall in none of them.
  assign is_binary = (opcode >= OP_ADD) && (opcode <= OP_ROL);
  assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign is_unary  = (opcode == OP_NEG) || (opcode == OP_NOT);
  assign is_halt   = (opcode == OP_HALT);
  assign is_exec   = is_binary || is_muldiv || is_unary;

  // State register; clear wins from any state, HALT included.
  always_ff @(posedge clock) begin
    if (clear) state <= T0;
    else       state <= next_state;
  end

  // Sequencing: fetch, then a class-dependent number of execute steps back to T0.
  always_comb begin
    next_state = state;
    case (state)
      T0:      next_state = T1;
      T1:      next_state = T2;
      T2: begin
        if (is_halt)      next_state = HALT;
        else if (is_exec) next_state = T3;
        else              next_state = T0;
      end
      T3:      next_state = is_exec ? T4 : T0;
      T4:      next_state = (is_binary || is_muldiv) ? T5 : T0;
      T5:      next_state = is_muldiv ? T6 : T0;
      T6:      next_state = T0;
      HALT:    next_state = HALT;
      default: next_state = T0;
    endcase
  end

  // Strobe decode from state and IR; clear silences every strobe while held.
  always_comb begin
    bus.PCout    = 1'b0;
    bus.IncPC    = 1'b0;
    bus.MARin    = 1'b0;
    bus.Zin      = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.Zhighout = 1'b0;
    bus.PCin     = 1'b0;
    bus.Read     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MDRout   = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.LOin     = 1'b0;
    bus.HIin     = 1'b0;
    bus.alu_op   = 5'b00000;
    bus.Rin      = 16'h0000;
    bus.Rout     = 16'h0000;
    bus.Run      = (state != HALT);
    bus.step     = state;
    if (!clear) begin
      case (state)
        T0: begin
          bus.PCout = 1'b1;
          bus.MARin = 1'b1;
          bus.IncPC = 1'b1;
          bus.Zin   = 1'b1;
        end
        T1: begin
          bus.Zlowout = 1'b1;
          bus.PCin    = 1'b1;
          bus.Read    = 1'b1;
          bus.MDRin   = 1'b1;
        end
        T2: begin
          bus.MDRout = 1'b1;
          bus.IRin   = 1'b1;
        end
        T3: begin
          if (is_binary) begin
            bus.Rout = 16'(1) << rb;
            bus.Yin  = 1'b1;
          end else if (is_muldiv) begin
            bus.Rout = 16'(1) << ra;
            bus.Yin  = 1'b1;
          end else if (is_unary) begin
            bus.Rout   = 16'(1) << rb;
            bus.alu_op = opcode;
            bus.Zin    = 1'b1;
          end
        end
        T4: begin
          if (is_binary) begin
            bus.Rout   = 16'(1) << rc;
            bus.alu_op = opcode;
            bus.Zin    = 1'b1;
          end else if (is_muldiv) begin
            bus.Rout   = 16'(1) << rb;
            bus.alu_op = opcode;
            bus.Zin    = 1'b1;
          end else if (is_unary) begin
            bus.Zlowout = 1'b1;
            bus.Rin     = 16'(1) << ra;
          end
        end
        T5: begin
          if (is_binary) begin
            bus.Zlowout = 1'b1;
            bus.Rin     = 16'(1) << ra;
          end else if (is_muldiv) begin
            bus.Zlowout = 1'b1;
            bus.LOin    = 1'b1;
          end
        end
        T6: begin
          if (is_muldiv) begin
            bus.Zhighout = 1'b1;
            bus.HIin     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench: stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_control_unit;

  logic clock;
  logic clear;

  control_unit_if bus ();

  control_unit dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Strobe vector bit order: PCout IncPC MARin Zin Zlowout Zhighout PCin Read MDRin MDRout IRin Yin LOin HIin
  localparam logic [13:0] S_PCOUT    = 14'b10000000000000;
  localparam logic [13:0] S_INCPC    = 14'b01000000000000;
  localparam logic [13:0] S_MARIN    = 14'b00100000000000;
  localparam logic [13:0] S_ZIN      = 14'b00010000000000;
  localparam logic [13:0] S_ZLOWOUT  = 14'b00001000000000;
  localparam logic [13:0] S_ZHIGHOUT = 14'b00000100000000;
  localparam logic [13:0] S_PCIN     = 14'b00000010000000;
  localparam logic [13:0] S_READ     = 14'b00000001000000;
  localparam logic [13:0] S_MDRIN    = 14'b00000000100000;
  localparam logic [13:0] S_MDROUT   = 14'b00000000010000;
  localparam logic [13:0] S_IRIN     = 14'b00000000001000;
  localparam logic [13:0] S_YIN      = 14'b00000000000100;
  localparam logic [13:0] S_LOIN     = 14'b00000000000010;
  localparam logic [13:0] S_HIIN     = 14'b00000000000001;
  localparam logic [13:0] S_NONE     = 14'b00000000000000;

  localparam logic [13:0] F_T0 = S_PCOUT | S_MARIN | S_INCPC | S_ZIN;
  localparam logic [13:0] F_T1 = S_ZLOWOUT | S_PCIN | S_READ | S_MDRIN;
  localparam logic [13:0] F_T2 = S_MDROUT | S_IRIN;

  localparam logic [31:0] IR_AND  = 32'h28918000;
  localparam logic [31:0] IR_MUL  = 32'h7A280000;
  localparam logic [31:0] IR_NEG  = 32'h8B380000;
  localparam logic [31:0] IR_NOP  = 32'hD0000000;
  localparam logic [31:0] IR_UNDF = 32'hF8000000;
  localparam logic [31:0] IR_HALT = 32'hD8000000;

  typedef struct packed {
    logic [3:0]  step;
    logic        run;
    logic [13:0] strb;
    logic [4:0]  alu;
    logic [15:0] rin;
    logic [15:0] rout;
  } out_t;

  typedef struct {
    out_t  v;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic out_t sample_outputs();
    out_t a;
    a.step = bus.step;
    a.run  = bus.Run;
    a.strb = {bus.PCout, bus.IncPC, bus.MARin, bus.Zin, bus.Zlowout, bus.Zhighout,
              bus.PCin, bus.Read, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.LOin, bus.HIin};
    a.alu  = bus.alu_op;
    a.rin  = bus.Rin;
    a.rout = bus.Rout;
    return a;
  endfunction

  // Compare one expected cycle against what the DUT presents.
  task automatic check_output(input exp_t e);
    out_t a;
    a = sample_outputs();
    checks++;
    if (a !== e.v) begin
      errors++;
      $display("[TB] FAIL %s: actual step=%0d run=%b strb=%b alu=%b rin=%h rout=%h, required step=%0d run=%b strb=%b alu=%b rin=%h rout=%h",
               e.tag, a.step, a.run, a.strb, a.alu, a.rin, a.rout,
               e.v.step, e.v.run, e.v.strb, e.v.alu, e.v.rin, e.v.rout);
    end
  endtask

  // Monitor: every cycle with a pending expectation is checked mid-cycle.
  always @(negedge clock) begin
    if (exp_q.size() > 0) check_output(exp_q.pop_front());
  end

  // Drive one cycle of inputs just after the edge and queue what that cycle must show.
  task automatic apply_stimulus(input logic clr, input logic [31:0] ir,
                                input logic [3:0] step, input logic run,
                                input logic [13:0] strb, input logic [4:0] alu,
                                input logic [15:0] rin, input logic [15:0] rout,
                                input string tag);
    exp_t e;
    @(posedge clock);
    #1;
    clear  = clr;
    bus.IR = ir;
    e.v.step = step;
    e.v.run  = run;
    e.v.strb = strb;
    e.v.alu  = alu;
    e.v.rin  = rin;
    e.v.rout = rout;
    e.tag    = tag;
    exp_q.push_back(e);
  endtask

  task automatic fetch(input logic [31:0] ir, input string name);
    apply_stimulus(1'b0, ir, 4'd0, 1'b1, F_T0, 5'd0, 16'h0, 16'h0, {name, "_T0"});
    apply_stimulus(1'b0, ir, 4'd1, 1'b1, F_T1, 5'd0, 16'h0, 16'h0, {name, "_T1"});
    apply_stimulus(1'b0, ir, 4'd2, 1'b1, F_T2, 5'd0, 16'h0, 16'h0, {name, "_T2"});
  endtask

  initial begin
    clear  = 1'b1;
    bus.IR = 32'h0;
    repeat (2) @(posedge clock);

    // Reset held: state T0, Run=1, everything silent
    apply_stimulus(1'b1, 32'h0, 4'd0, 1'b1, S_NONE, 5'd0, 16'h0, 16'h0, "reset_hold");

    // and R1,R2,R3
    fetch(IR_AND, "and");
    apply_stimulus(1'b0, IR_AND, 4'd3, 1'b1, S_YIN, 5'd0, 16'h0, 16'h0004, "and_T3");
    apply_stimulus(1'b0, IR_AND, 4'd4, 1'b1, S_ZIN, 5'b00101, 16'h0, 16'h0008, "and_T4");
    apply_stimulus(1'b0, IR_AND, 4'd5, 1'b1, S_ZLOWOUT, 5'd0, 16'h0002, 16'h0, "and_T5");

    // mul R4,R5
    fetch(IR_MUL, "mul");
    apply_stimulus(1'b0, IR_MUL, 4'd3, 1'b1, S_YIN, 5'd0, 16'h0, 16'h0010, "mul_T3");
    apply_stimulus(1'b0, IR_MUL, 4'd4, 1'b1, S_ZIN, 5'b01111, 16'h0, 16'h0020, "mul_T4");
    apply_stimulus(1'b0, IR_MUL, 4'd5, 1'b1, S_ZLOWOUT | S_LOIN, 5'd0, 16'h0, 16'h0, "mul_T5");
    apply_stimulus(1'b0, IR_MUL, 4'd6, 1'b1, S_ZHIGHOUT | S_HIIN, 5'd0, 16'h0, 16'h0, "mul_T6");

    // neg R6,R7
    fetch(IR_NEG, "neg");
    apply_stimulus(1'b0, IR_NEG, 4'd3, 1'b1, S_ZIN, 5'b10001, 16'h0, 16'h0080, "neg_T3");
    apply_stimulus(1'b0, IR_NEG, 4'd4, 1'b1, S_ZLOWOUT, 5'd0, 16'h0040, 16'h0, "neg_T4");

    // nop and an undefined opcode go straight back to fetch
    fetch(IR_NOP, "nop");
    fetch(IR_UNDF, "undef");

    // Mid-instruction clear during T4 of "and"
    fetch(IR_AND, "and_rst");
    apply_stimulus(1'b0, IR_AND, 4'd3, 1'b1, S_YIN, 5'd0, 16'h0, 16'h0004, "and_rst_T3");
    apply_stimulus(1'b1, IR_AND, 4'd4, 1'b1, S_NONE, 5'd0, 16'h0, 16'h0, "and_rst_T4_clear");
    fetch(IR_NOP, "after_rst");

    // halt: sticky for 20 cycles, left only by clear
    fetch(IR_HALT, "halt");
    for (int i = 0; i < 21; i++)
      apply_stimulus(1'b0, IR_HALT, 4'd15, 1'b0, S_NONE, 5'd0, 16'h0, 16'h0, "halt_hold");
    apply_stimulus(1'b1, IR_HALT, 4'd15, 1'b0, S_NONE, 5'd0, 16'h0, 16'h0, "halt_clear");
    fetch(IR_AND, "post_halt");

    // Let the monitor drain the queue, bounded
    begin
      int waited;
      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
        @(posedge clock);
        waited++;
      end
      if (exp_q.size() > 0) begin
        errors++;
        $display("[TB] FAIL drain: actual pending=%0d, required pending=0", exp_q.size());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
